led_matrix_scan: RTL
====================

# led_matrix_scan

Row-multiplexed driver for the 8x8 LED matrix. It sits directly downstream of the CPU and owns the board's `col`/`row` pins. The CPU writes pixel rows into an internal frame buffer over a simple write port. The block continuously scans the buffer one row at a time at a fixed refresh rate, inserting a blanking gap between rows to suppress ghosting.

## Interface
Parameters:
- `DIV`, default 3375: clocks per row slot (27 MHz / 3375 = 8 kHz row rate, 1 kHz frame rate); must be ≥ `BLANK`+2.
- `BLANK`, default 16: clocks of all-off blanking at the start of each row slot; must be ≥ 1.

Ports:
- `clk` in 1: system clock. One clock; all logic on posedge.
- `rst` in 1: reset, asynchronous, active-low.
- `we` in 1: write strobe, one row per cycle.
- `w_row` in 3: row index written.
- `w_data` in 8: pixel bits for that row; bit n drives column n.
- `swap` in 1: request buffer swap (pulse; meaningful only with double buffering).
- `col` out 8: column drive, active-high.
- `row` out 8: row select, one-hot active-low.
- `frame_start` out 1: one-cycle pulse when row 0 begins its display phase.
- `swap_done` out 1: one-cycle pulse when a requested swap takes effect.

## Operation
- FSM states `BLANK` and `SHOW`; reset enters `BLANK` with row index 0.
- `BLANK`:
  - `row`=8'hFF, `col`=8'h00.
  - Lasts `BLANK` cycles.
  - On the last cycle, the buffer row for the current index is latched into a display register.
  - Transition to `SHOW`.
- `SHOW`:
  - `row` has only bit[idx] low; `col` = latched data.
  - Lasts `DIV`−`BLANK` cycles.
  - Then the index increments mod 8 (7→0 wraps) and the FSM returns to `BLANK`.
- Slot counter: ceil(log2(`DIV`)) bits; cleared on every state transition.
- Writes: on `we`, `w_data` goes into `w_row` of the write buffer.
  - A write to the row currently in `SHOW` does not change `col` until that row's next slot.
  - Back-to-back writes are accepted every cycle; there is no backpressure.
- `frame_start` pulses on the `BLANK`→`SHOW` edge of row 0.
- Reset mid-scan: outputs blank immediately (asynchronous) and the FSM restarts at row 0. Frame buffer contents are cleared to 0.

## Timing
- Reset values:
  - `row`=8'hFF, `col`=8'h00, `frame_start`=0, `swap_done`=0.
  - State `BLANK`, index 0, counter 0.
- All outputs are registered; no combinational path from inputs to outputs.
- First lit row: `SHOW` begins `BLANK` cycles after reset release.
- Row period is exactly `DIV` cycles; frame period is exactly 8·`DIV` cycles.
- Write-to-display latency: at most 8·`DIV`+`BLANK` cycles; at least 1 cycle when the written row is latched on the following cycle.
- Simultaneous `we` on the row being latched on the same cycle: the old data is displayed (read-before-write).

## Configuration
- `LEDM_DOUBLE_BUF_EN` defined:
  - Two banks. Writes always go to the back bank; the scan reads the front bank.
  - A `swap` pulse sets a pending flag; repeated pulses while pending coalesce into one.
  - The swap executes at the end of row 7's `SHOW` (frame boundary), so a frame never tears.
  - `swap_done` pulses that same cycle and the pending flag clears.
  - A `swap` arriving on the boundary cycle itself is deferred to the next frame.
- `LEDM_DOUBLE_BUF_EN` undefined:
  - Single bank, shared by writes and scan.
  - `swap` is ignored; `swap_done` is tied 0.

## Structure
- Package `ledm_pkg`:
  - `NUM_ROWS`=8, `ROW_W`=3, `COL_W`=8.
  - State enum `ledm_state_t` {`BLANK`, `SHOW`}.
  - Idle constants `ROW_OFF`=8'hFF, `COL_OFF`=8'h00.
- Sub-module `ledm_fb`: frame-buffer storage (1 or 2 banks of 8×8), synchronous write, registered read by row index, bank-select input. The scan FSM, counters and swap logic stay in `led_matrix_scan`.

## Test plan
Bench uses `DIV`=8, `BLANK`=2.
- Reset, no writes:
  - `row` stays 8'hFF for 2 cycles after `rst` rises, then walks 8'hFE, 8'hFD, … every 8 cycles.
  - `col`=0 throughout.
  - `frame_start` pulses every 64 cycles.
- Write row 3=8'hA5, single-buffer build: when `row`=8'hF7, `col`=8'hA5; all other rows show 0; 2 blank cycles precede each row.
- Write to the row currently in `SHOW`: `col` is unchanged for the rest of that slot, and the new value appears in that row's next slot, 64 cycles later.
- `LEDM_DOUBLE_BUF_EN`, write all rows 8'hFF, no swap: `col` stays 0.
  - `swap` mid-frame → `swap_done` pulses at the row 7 boundary.
  - Next frame shows 8'hFF on all rows.
  - Three `swap` pulses within one frame yield exactly one `swap_done`.
- Assert `rst` low during `SHOW` of row 5:
  - Same cycle: `row`=8'hFF, `col`=0.
  - After release: scan restarts at row 0 and the buffer reads back 0.

Source files
------------

// File: rtl/ledm_pkg.sv
// Shared constants, state type and row-select helper for the LED matrix scanner.
package ledm_pkg;
    localparam int NUM_ROWS = 8;
    localparam int ROW_W    = 3;
    localparam int COL_W    = 8;

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} ledm_state_t;

    localparam logic [NUM_ROWS-1:0] ROW_OFF = 8'hFF;
    localparam logic [COL_W-1:0]    COL_OFF = 8'h00;

    // One-hot active-low select for a row index.
    function automatic logic [NUM_ROWS-1:0] row_sel(input logic [ROW_W-1:0] idx);
        return ~(NUM_ROWS'(1) << idx);
    endfunction
endpackage

// File: rtl/ledm_fb.sv
// Frame-buffer storage: 1 or 2 banks of 8x8 bits, synchronous write, registered row read.
// rd_data is the display register; it is cleared on rd_clr so the column pins blank.
module ledm_fb
    import ledm_pkg::*;
#(
    parameter int NUM_BANKS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             w_bank,
    input  logic [ROW_W-1:0] w_row,
    input  logic [COL_W-1:0] w_data,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic             rd_bank,
    input  logic [ROW_W-1:0] rd_row,
    output logic [COL_W-1:0] rd_data
);
    logic [NUM_BANKS-1:0][NUM_ROWS-1:0][COL_W-1:0] mem;
    logic wb, rb;

    assign wb = (NUM_BANKS > 1) ? w_bank  : 1'b0;
    assign rb = (NUM_BANKS > 1) ? rd_bank : 1'b0;

    // Read and write share an edge, so a same-cycle write to the latched row shows the old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem     <= '0;
            rd_data <= COL_OFF;
        end else begin
            if (we)
                mem[wb][w_row] <= w_data;
            if (rd_en)
                rd_data <= mem[rb][rd_row];
            else if (rd_clr)
                rd_data <= COL_OFF;
        end
    end
endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver with blanking gap between rows.
// Define LEDM_DOUBLE_BUF_EN for two banks with tear-free swap at the frame boundary.
module led_matrix_scan
    import ledm_pkg::NUM_ROWS, ledm_pkg::ROW_W, ledm_pkg::ledm_state_t,
           ledm_pkg::ROW_OFF, ledm_pkg::row_sel;
#(
    parameter int DIV   = 3375,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] w_row,
    input  logic [7:0] w_data,
    input  logic       swap,
    output logic [7:0] col,
    output logic [7:0] row,
    output logic       frame_start,
    output logic       swap_done
);
    localparam int            CW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - BLANK - 1);

    ledm_state_t      state;
    logic [CW-1:0]    cnt;
    logic [ROW_W-1:0] idx;
    logic             blank_end, show_end, frame_end;
    logic             front, wr_bank;

    assign blank_end = (state == ledm_pkg::BLANK) && (cnt == BLANK_LAST);
    assign show_end  = (state == ledm_pkg::SHOW)  && (cnt == SHOW_LAST);
    assign frame_end = show_end && (idx == ROW_W'(NUM_ROWS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ledm_pkg::BLANK;
            cnt         <= '0;
            idx         <= '0;
            row         <= ROW_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= blank_end && (idx == '0);
            if (blank_end) begin
                state <= ledm_pkg::SHOW;
                cnt   <= '0;
                row   <= row_sel(idx);
            end else if (show_end) begin
                state <= ledm_pkg::BLANK;
                cnt   <= '0;
                idx   <= idx + 1'b1;
                row   <= ROW_OFF;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef LEDM_DOUBLE_BUF_EN
    localparam int NUM_BANKS = 2;
    logic pending;

    // A swap seen on the boundary cycle itself only arms the next frame's swap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front     <= 1'b0;
            pending   <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= frame_end && pending;
            if (frame_end) begin
                pending <= swap;
                if (pending)
                    front <= ~front;
            end else if (swap) begin
                pending <= 1'b1;
            end
        end
    end
    assign wr_bank = ~front;
`else
    localparam int NUM_BANKS = 1;
    logic unused_swap;
    assign unused_swap = swap;
    assign front       = 1'b0;
    assign wr_bank     = 1'b0;
    assign swap_done   = 1'b0;
`endif

    ledm_fb #(.NUM_BANKS(NUM_BANKS)) u_fb (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .w_bank  (wr_bank),
        .w_row   (w_row),
        .w_data  (w_data),
        .rd_en   (blank_end),
        .rd_clr  (show_end),
        .rd_bank (front),
        .rd_row  (idx),
        .rd_data (col)
    );
endmodule
